// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: two-requester writeback arbiter for a register file, plus an
// optional pending-write scoreboard for source-operand hazard checks.
//
// Ports:
//   clk_i, reset_i                   clock, synchronous active-high reset
//   reqX_valid_i/rd_i/data_i         writeback request from requester X (0 = ALU, 1 = multi-cycle)
//   reqX_ready_o                     request X accepted this cycle (combinational)
//   w_enable_o, rd_o, wdata_o        registered write port to the register file
//   issue_valid_i, issue_rd_i        instruction issuing with destination issue_rd_i
//   chk_rs_i, chk_rt_i               source registers to hazard-check
//   rs_busy_o, rt_busy_o             source register has an uncommitted write pending
//   sb_err_o                         sticky: a commit hit a register with nothing pending
//
// Build option: define RF_WB_SCOREBOARD_EN to include the scoreboard. Without it the
// busy/error outputs are tied low and the issue/check inputs are ignored.
module rf_wb_arbiter #(
    parameter int unsigned M  = 32,
    parameter int unsigned N  = 8,
    localparam int unsigned AW = $clog2(M)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          req0_valid_i,
    input  logic [AW-1:0] req0_rd_i,
    input  logic [N-1:0]  req0_data_i,
    output logic          req0_ready_o,
    input  logic          req1_valid_i,
    input  logic [AW-1:0] req1_rd_i,
    input  logic [N-1:0]  req1_data_i,
    output logic          req1_ready_o,
    output logic          w_enable_o,
    output logic [AW-1:0] rd_o,
    output logic [N-1:0]  wdata_o,
    input  logic          issue_valid_i,
    input  logic [AW-1:0] issue_rd_i,
    input  logic [AW-1:0] chk_rs_i,
    input  logic [AW-1:0] chk_rt_i,
    output logic          rs_busy_o,
    output logic          rt_busy_o,
    output logic          sb_err_o
);

    // last_grant_q = 1 means requester 1 won the most recent grant cycle.
    logic          last_grant_q, last_grant_d;
    logic          w_enable_q, w_enable_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [N-1:0]  wdata_q, wdata_d;

    logic          gnt0, gnt1, gnt_any;
    logic [AW-1:0] gnt_rd;
    logic [N-1:0]  gnt_data;
    logic          commit;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset_i) begin
            if (req0_valid_i && req1_valid_i) begin
                gnt0 = last_grant_q;
                gnt1 = ~last_grant_q;
            end else begin
                gnt0 = req0_valid_i;
                gnt1 = req1_valid_i;
            end
        end
    end

    assign gnt_any      = gnt0 | gnt1;
    assign gnt_rd       = gnt1 ? req1_rd_i : req0_rd_i;
    assign gnt_data     = gnt1 ? req1_data_i : req0_data_i;
    // Writes to register 0 complete the handshake but never reach the file.
    assign commit       = gnt_any && (gnt_rd != '0);
    assign req0_ready_o = gnt0;
    assign req1_ready_o = gnt1;

    always_comb begin
        w_enable_d   = commit;
        rd_d         = gnt_any ? gnt_rd : rd_q;
        wdata_d      = gnt_any ? gnt_data : wdata_q;
        last_grant_d = gnt_any ? gnt1 : last_grant_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_grant_q <= 1'b1;
            w_enable_q   <= 1'b0;
            rd_q         <= '0;
            wdata_q      <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            w_enable_q   <= w_enable_d;
            rd_q         <= rd_d;
            wdata_q      <= wdata_d;
        end
    end

    assign w_enable_o = w_enable_q;
    assign rd_o       = rd_q;
    assign wdata_o    = wdata_q;

`ifdef RF_WB_SCOREBOARD_EN
    // Bit 0 exists only to allow direct indexing; it is never set.
    logic [M-1:0] pending_q, pending_d;
    logic [M-1:0] set_vec, clr_vec;
    logic         sb_err_q, sb_err_d;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_valid_i && (issue_rd_i != '0)) set_vec = M'(1) << issue_rd_i;
        if (commit)                              clr_vec = M'(1) << gnt_rd;
        // OR-ing the set after the clear makes a same-cycle issue win.
        pending_d = (pending_q & ~clr_vec) | set_vec;
        sb_err_d  = sb_err_q | (commit && !pending_q[gnt_rd] && !set_vec[gnt_rd]);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pending_q <= '0;
            sb_err_q  <= 1'b0;
        end else begin
            pending_q <= pending_d;
            sb_err_q  <= sb_err_d;
        end
    end

    assign rs_busy_o = pending_q[chk_rs_i];
    assign rt_busy_o = pending_q[chk_rt_i];
    assign sb_err_o  = sb_err_q;
`else
    logic unused_sb_inputs;
    assign unused_sb_inputs = ^{issue_valid_i, issue_rd_i, chk_rs_i, chk_rt_i};
    assign rs_busy_o = 1'b0;
    assign rt_busy_o = 1'b0;
    assign sb_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural model of grants, write port and scoreboard.
module tb_rf_wb_arbiter;
    localparam int unsigned M  = 32;
    localparam int unsigned N  = 8;
    localparam int unsigned AW = $clog2(M);
`ifdef RF_WB_SCOREBOARD_EN
    localparam bit SB_EN = 1'b1;
`else
    localparam bit SB_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [AW-1:0] req0_rd, req1_rd, rd, issue_rd, chk_rs, chk_rt;
    logic [N-1:0]  req0_data, req1_data, wdata;
    logic          w_enable, issue_valid, rs_busy, rt_busy, sb_err;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.M(M), .N(N)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .req0_valid_i (req0_valid),
        .req0_rd_i    (req0_rd),
        .req0_data_i  (req0_data),
        .req0_ready_o (req0_ready),
        .req1_valid_i (req1_valid),
        .req1_rd_i    (req1_rd),
        .req1_data_i  (req1_data),
        .req1_ready_o (req1_ready),
        .w_enable_o   (w_enable),
        .rd_o         (rd),
        .wdata_o      (wdata),
        .issue_valid_i(issue_valid),
        .issue_rd_i   (issue_rd),
        .chk_rs_i     (chk_rs),
        .chk_rt_i     (chk_rt),
        .rs_busy_o    (rs_busy),
        .rt_busy_o    (rt_busy),
        .sb_err_o     (sb_err)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model state.
    int          m_last;
    bit          m_we, m_err;
    bit [AW-1:0] m_rd;
    bit [N-1:0]  m_wd;
    bit          m_pend[M];

    typedef struct packed {
        logic          r0;
        logic          r1;
        logic          rsb;
        logic          rtb;
        logic          we;
        logic [AW-1:0] rd;
        logic [N-1:0]  wd;
        logic          err;
    } snap_t;

    // -1: no grant this cycle, else index of the granted requester.
    function automatic int model_grant();
        if (reset) return -1;
        if (req0_valid && req1_valid) return 1 - m_last;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    task automatic model_edge(input int g);
        bit [AW-1:0] grd;
        bit          setting;
        if (reset) begin
            m_last = 1; m_we = 0; m_rd = '0; m_wd = '0; m_err = 0;
            foreach (m_pend[i]) m_pend[i] = 0;
        end else begin
            grd = (g == 1) ? req1_rd : req0_rd;
            if (g >= 0) begin
                m_last = g;
                m_we   = (grd != 0);
                m_rd   = grd;
                m_wd   = (g == 1) ? req1_data : req0_data;
            end else begin
                m_we = 0;
            end
            if (SB_EN) begin
                setting = issue_valid && (issue_rd != 0);
                if (g >= 0 && grd != 0) begin
                    if (!m_pend[grd] && !(setting && issue_rd == grd)) m_err = 1;
                    m_pend[grd] = 0;
                end
                if (setting) m_pend[issue_rd] = 1;
            end
        end
    endtask

    task automatic drive(input logic rst, input logic v0, input logic [AW-1:0] rd0,
                         input logic [N-1:0] d0, input logic v1, input logic [AW-1:0] rd1,
                         input logic [N-1:0] d1, input logic iv = 1'b0,
                         input logic [AW-1:0] ird = '0, input logic [AW-1:0] crs = '0,
                         input logic [AW-1:0] crt = '0);
        reset = rst;
        req0_valid = v0; req0_rd = rd0; req0_data = d0;
        req1_valid = v1; req1_rd = rd1; req1_data = d1;
        issue_valid = iv; issue_rd = ird; chk_rs = crs; chk_rt = crt;
    endtask

    // Called at posedge+1 after drive(); returns at the next posedge+1 with
    // combinational outputs sampled mid-cycle and registered outputs after the edge.
    task automatic run_cycle(output snap_t obs, output snap_t exp);
        int g;
        #4;
        g = model_grant();
        obs.r0 = req0_ready; obs.r1 = req1_ready; obs.rsb = rs_busy; obs.rtb = rt_busy;
        exp.r0 = (g == 0); exp.r1 = (g == 1);
        exp.rsb = SB_EN && m_pend[chk_rs];
        exp.rtb = SB_EN && m_pend[chk_rt];
        @(posedge clk);
        model_edge(g);
        #1;
        obs.we = w_enable; obs.rd = rd; obs.wd = wdata; obs.err = sb_err;
        exp.we = m_we; exp.rd = m_rd; exp.wd = m_wd; exp.err = m_err;
    endtask

    task automatic test_reset();
        snap_t o, e;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 5'd3, 8'h55, 1'b1, 5'd4, 8'h66, 1'b1, 5'd3, 5'd3, 5'd4);
            run_cycle(o, e);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL reset_model[%0d]: got %h want %h", i, o, e);
            end
            checks++;
            if ({o.r0, o.r1, o.we, o.rd, o.wd, o.err} !== '0) begin
                failures++;
                $display("FAIL reset_state[%0d]: got %h want 0", i,
                         {o.r0, o.r1, o.we, o.rd, o.wd, o.err});
            end
        end
    endtask

    task automatic test_single();
        snap_t o, e;
        drive(1'b0, 1'b1, 5'd5, 8'hA3, 1'b0, '0, '0);
        run_cycle(o, e);
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL single_model: got %h want %h", o, e);
        end
        checks++;
        if ({o.r0, o.r1, o.we, o.rd, o.wd} !== {1'b1, 1'b0, 1'b1, 5'd5, 8'hA3}) begin
            failures++;
            $display("FAIL single_write: got r0=%b r1=%b we=%b rd=%0d wd=%h want 1 0 1 5 a3",
                     o.r0, o.r1, o.we, o.rd, o.wd);
        end
        // Idle cycle: enable drops, address/data hold.
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        run_cycle(o, e);
        checks++;
        if ({o.we, o.rd, o.wd} !== {1'b0, 5'd5, 8'hA3}) begin
            failures++;
            $display("FAIL idle_hold: got we=%b rd=%0d wd=%h want 0 5 a3", o.we, o.rd, o.wd);
        end
    endtask

    task automatic test_round_robin();
        snap_t o, e;
        drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        run_cycle(o, e);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 5'd1, 8'(8'h10 + i), 1'b1, 5'd2, 8'(8'h20 + i));
            run_cycle(o, e);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL rr_model[%0d]: got %h want %h", i, o, e);
            end
            checks++;
            if ({o.r0, o.r1, o.we, o.rd} !== {(i % 2 == 0), (i % 2 == 1), 1'b1,
                                              (i % 2 == 0) ? 5'd1 : 5'd2}) begin
                failures++;
                $display("FAIL rr_grant[%0d]: got r0=%b r1=%b we=%b rd=%0d want grant %0d",
                         i, o.r0, o.r1, o.we, o.rd, i % 2);
            end
        end
    endtask

    task automatic test_rd_zero();
        snap_t o, e;
        drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 8'hFF);
        run_cycle(o, e);
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL rd0_model: got %h want %h", o, e);
        end
        checks++;
        if ({o.r1, o.we, o.err} !== 3'b100) begin
            failures++;
            $display("FAIL rd0_drop: got r1=%b we=%b err=%b want 1 0 0", o.r1, o.we, o.err);
        end
    endtask

    task automatic test_scoreboard();
        snap_t o, e;
        // Issue r7, then commit r7, then same-cycle issue+commit of r7.
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7, 5'd0, 5'd0);
        run_cycle(o, e);
        drive(1'b0, 1'b1, 5'd7, 8'h11, 1'b0, '0, '0, 1'b0, 5'd0, 5'd7, 5'd0);
        run_cycle(o, e);
        checks++;
        if (o.rsb !== SB_EN) begin
            failures++;
            $display("FAIL sb_busy_after_issue: got %b want %b", o.rsb, SB_EN);
        end
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 5'd0, 5'd7, 5'd7);
        run_cycle(o, e);
        checks++;
        if ({o.rsb, o.rtb} !== 2'b00) begin
            failures++;
            $display("FAIL sb_busy_after_commit: got %b%b want 00", o.rsb, o.rtb);
        end
        drive(1'b0, 1'b1, 5'd7, 8'h22, 1'b0, '0, '0, 1'b1, 5'd7, 5'd7, 5'd0);
        run_cycle(o, e);
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 5'd0, 5'd7, 5'd0);
        run_cycle(o, e);
        checks++;
        if ({o.rsb, o.err} !== {SB_EN, 1'b0}) begin
            failures++;
            $display("FAIL sb_set_wins: got busy=%b err=%b want %b 0", o.rsb, o.err, SB_EN);
        end
        // Commit r9 with nothing pending.
        drive(1'b0, 1'b1, 5'd9, 8'h33, 1'b0, '0, '0, 1'b0, 5'd0, 5'd7, 5'd9);
        run_cycle(o, e);
        checks++;
        if (o.err !== SB_EN) begin
            failures++;
            $display("FAIL sb_err_set: got %b want %b", o.err, SB_EN);
        end
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        run_cycle(o, e);
        checks++;
        if (o !== e || o.err !== SB_EN) begin
            failures++;
            $display("FAIL sb_err_sticky: got %h want %h", o, e);
        end
        drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 5'd0, 5'd7, 5'd9);
        run_cycle(o, e);
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 5'd0, 5'd7, 5'd9);
        run_cycle(o, e);
        checks++;
        if ({o.rsb, o.rtb, o.err, o.we} !== 4'b0000) begin
            failures++;
            $display("FAIL sb_reset_clear: got busy=%b%b err=%b we=%b want 0000",
                     o.rsb, o.rtb, o.err, o.we);
        end
    endtask

    task automatic test_reset_drop();
        snap_t o, e;
        drive(1'b1, 1'b1, 5'd12, 8'h5A, 1'b0, '0, '0);
        run_cycle(o, e);
        checks++;
        if ({o.r0, o.we} !== 2'b00) begin
            failures++;
            $display("FAIL reset_drop: got r0=%b we=%b want 0 0", o.r0, o.we);
        end
        drive(1'b0, 1'b1, 5'd12, 8'h5A, 1'b0, '0, '0);
        run_cycle(o, e);
        checks++;
        if ({o.r0, o.we, o.rd, o.wd} !== {1'b1, 1'b1, 5'd12, 8'h5A}) begin
            failures++;
            $display("FAIL reset_retry: got %h want %h", o, e);
        end
    endtask

    task automatic test_random();
        snap_t o, e;
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 24) == 0),
                  1'($urandom), AW'($urandom_range(0, M - 1)), N'($urandom),
                  1'($urandom), AW'($urandom_range(0, M - 1)), N'($urandom),
                  1'($urandom), AW'($urandom_range(0, M - 1)),
                  AW'($urandom_range(0, M - 1)), AW'($urandom_range(0, M - 1)));
            run_cycle(o, e);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL random[%0d]: got %h want %h", i, o, e);
            end
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        m_last = 1; m_we = 0; m_rd = '0; m_wd = '0; m_err = 0;
        foreach (m_pend[i]) m_pend[i] = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_rd_zero();
        test_scoreboard();
        test_reset_drop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
